// File: rtl/riscv_dmem_ctrl.sv
// Data-memory controller for the MEM stage: byte/half/word loads and stores on a word array,
// with programmable wait states, a stall handshake and memory trace outputs.
module riscv_dmem_ctrl #(
  parameter int DEPTH = 128,
  parameter int WAIT  = 1,
  localparam int ADDR_W = $clog2(DEPTH) + 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              stall,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              fault,
  output logic              wr,
  output logic              rd,
  output logic [ADDR_W-1:0] addr,
  output logic [31:0]       wr_data,
  output logic [31:0]       rd_data
);

  localparam int IDX_W = ADDR_W - 2;
  localparam logic [3:0] CNT_INIT = (WAIT > 0) ? 4'(WAIT - 1) : 4'd0;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t            state_reg;
  logic [3:0]        cnt_reg;
  logic              we_reg;
  logic [2:0]        funct3_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [31:0]       wdata_reg;

  logic [31:0] mem [DEPTH];

  logic              in_idle;
  logic              acc_we;
  logic [2:0]        acc_f3;
  logic [ADDR_W-1:0] acc_addr;
  logic [31:0]       acc_wdata;
  logic [IDX_W-1:0]  word_idx;
  logic [1:0]        lane;
  logic [31:0]       old_word;
  logic [31:0]       store_word;
  logic [31:0]       merged_word;
  logic [31:0]       load_word;
  logic [31:0]       load_ext;
  logic [3:0]        byte_en;
  logic              legal;
  logic              access_fire;
  logic              fault_fire;

  // With zero wait states the access happens on the accept edge, so the live
  // request fields are used in IDLE and the latched copy afterwards.
  assign in_idle   = (state_reg == IDLE);
  assign acc_we    = in_idle ? req_we     : we_reg;
  assign acc_f3    = in_idle ? req_funct3 : funct3_reg;
  assign acc_addr  = in_idle ? req_addr   : addr_reg;
  assign acc_wdata = in_idle ? req_wdata  : wdata_reg;
  assign word_idx  = acc_addr[ADDR_W-1:2];
  assign lane      = acc_addr[1:0];
  assign old_word  = mem[word_idx];

  assign store_word = acc_wdata << {lane, 3'b000};
  assign load_word  = old_word >> {lane, 3'b000};

  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign byte_en[gi] = (acc_f3[1:0] == 2'b10) |
                         ((acc_f3[1:0] == 2'b01) & (lane[1] == 1'(gi / 2))) |
                         ((acc_f3[1:0] == 2'b00) & (lane == 2'(gi)));
    assign merged_word[gi*8 +: 8] = byte_en[gi] ? store_word[gi*8 +: 8] : old_word[gi*8 +: 8];
  end

  always_comb begin
    case (acc_f3)
      3'b000:  load_ext = {{24{load_word[7]}}, load_word[7:0]};
      3'b001:  load_ext = {{16{load_word[15]}}, load_word[15:0]};
      3'b100:  load_ext = {24'd0, load_word[7:0]};
      3'b101:  load_ext = {16'd0, load_word[15:0]};
      default: load_ext = old_word;
    endcase
  end

  // Legality is only evaluated on the accept cycle, so it looks at the live request.
  always_comb begin
    legal = 1'b1;
    if (req_we && (req_funct3 > 3'd2))
      legal = 1'b0;
    if (!req_we && ((req_funct3 == 3'b011) || (req_funct3[2:1] == 2'b11)))
      legal = 1'b0;
    if ((req_funct3[1:0] == 2'b01) && req_addr[0])
      legal = 1'b0;
    if ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00))
      legal = 1'b0;
  end

  assign access_fire = (in_idle & req_valid & legal & (WAIT == 0)) |
                       ((state_reg == BUSY) & (cnt_reg == 4'd0));
  assign fault_fire  = in_idle & req_valid & ~legal;

  assign stall      = req_valid & (state_reg != DONE);
  assign resp_valid = (state_reg == DONE);

  // Reset gates the write so an aborted store never reaches the array.
  always_ff @(posedge clk) begin
    if (!reset && access_fire && acc_we)
      mem[word_idx] <= merged_word;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg  <= IDLE;
      cnt_reg    <= 4'd0;
      we_reg     <= 1'b0;
      funct3_reg <= 3'd0;
      addr_reg   <= '0;
      wdata_reg  <= 32'd0;
      resp_rdata <= 32'd0;
      fault      <= 1'b0;
      wr         <= 1'b0;
      rd         <= 1'b0;
      addr       <= '0;
      wr_data    <= 32'd0;
      rd_data    <= 32'd0;
    end else begin
      fault <= 1'b0;
      wr    <= 1'b0;
      rd    <= 1'b0;
      if (access_fire) begin
        addr <= acc_addr;
        if (acc_we) begin
          wr      <= 1'b1;
          wr_data <= merged_word;
        end else begin
          rd         <= 1'b1;
          rd_data    <= old_word;
          resp_rdata <= load_ext;
        end
      end
      if (fault_fire) begin
        fault      <= 1'b1;
        resp_rdata <= 32'd0;
        addr       <= req_addr;
      end
      case (state_reg)
        IDLE: begin
          if (req_valid) begin
            we_reg     <= req_we;
            funct3_reg <= req_funct3;
            addr_reg   <= req_addr;
            wdata_reg  <= req_wdata;
            if (!legal || (WAIT == 0)) begin
              state_reg <= DONE;
            end else begin
              cnt_reg   <= CNT_INIT;
              state_reg <= BUSY;
            end
          end
        end
        BUSY: begin
          if (cnt_reg == 4'd0)
            state_reg <= DONE;
          else
            cnt_reg <= cnt_reg - 4'd1;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_riscv_dmem_ctrl.sv
// Self-checking bench: three controllers (WAIT = 1, 0, 15) against a byte-addressed memory model.
module tb_riscv_dmem_ctrl;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int cycle_cnt = 0;
  always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

  logic        req_valid_a  [3];
  logic        req_we_a     [3];
  logic [2:0]  req_f3_a     [3];
  logic [8:0]  req_addr_a   [3];
  logic [31:0] req_wdata_a  [3];
  logic        stall_a      [3];
  logic        resp_valid_a [3];
  logic [31:0] resp_rdata_a [3];
  logic        fault_a      [3];
  logic        wr_a         [3];
  logic        rd_a         [3];
  logic [8:0]  addr_a       [3];
  logic [31:0] wr_data_a    [3];
  logic [31:0] rd_data_a    [3];

  for (genvar gi = 0; gi < 3; gi++) begin : g_dut
    riscv_dmem_ctrl #(
      .DEPTH(128),
      .WAIT ((gi == 0) ? 1 : ((gi == 1) ? 0 : 15))
    ) dut (
      .clk       (clk),
      .reset     (reset),
      .req_valid (req_valid_a[gi]),
      .req_we    (req_we_a[gi]),
      .req_funct3(req_f3_a[gi]),
      .req_addr  (req_addr_a[gi]),
      .req_wdata (req_wdata_a[gi]),
      .stall     (stall_a[gi]),
      .resp_valid(resp_valid_a[gi]),
      .resp_rdata(resp_rdata_a[gi]),
      .fault     (fault_a[gi]),
      .wr        (wr_a[gi]),
      .rd        (rd_a[gi]),
      .addr      (addr_a[gi]),
      .wr_data   (wr_data_a[gi]),
      .rd_data   (rd_data_a[gi])
    );
  end

  int vectors = 0;
  int miscompares = 0;

  // Reference memory: plain byte array per instance.
  logic [7:0] mb [3][512];

  // Results of the last transaction.
  int          last_lat;
  int          last_stalls;
  int          last_cyc;
  bit          last_to;
  logic [31:0] lo_rdata;
  logic        lo_fault;
  logic        lo_wr;
  logic        lo_rd;
  logic [8:0]  lo_addr;
  logic [31:0] lo_wdata;
  logic [31:0] lo_rword;

  function automatic int wait_of(int k);
    return (k == 0) ? 1 : ((k == 1) ? 0 : 15);
  endfunction

  function automatic bit is_legal(bit we, logic [2:0] f3, logic [8:0] a);
    int size;
    if (we && !(f3 inside {3'd0, 3'd1, 3'd2})) return 1'b0;
    if (!we && !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) return 1'b0;
    size = 1 << f3[1:0];
    return (int'(a) % size) == 0;
  endfunction

  function automatic logic [31:0] model_word(int k, logic [8:0] a);
    int b;
    b = int'(a) & ~3;
    return {mb[k][b+3], mb[k][b+2], mb[k][b+1], mb[k][b]};
  endfunction

  function automatic logic [31:0] model_load(int k, logic [2:0] f3, logic [8:0] a);
    logic [7:0]  by;
    logic [15:0] h;
    by = mb[k][int'(a)];
    h  = {mb[k][(int'(a) + 1) % 512], mb[k][int'(a)]};
    case (f3)
      3'd0: return {{24{by[7]}}, by};
      3'd4: return {24'd0, by};
      3'd1: return {{16{h[15]}}, h};
      3'd5: return {16'd0, h};
      default: return model_word(k, a);
    endcase
  endfunction

  task automatic model_store(int k, logic [2:0] f3, logic [8:0] a, logic [31:0] wd);
    int n;
    int base;
    n = 1 << f3[1:0];
    base = int'(a);
    for (int i = 0; i < n; i++) mb[k][base + i] = wd[i*8 +: 8];
  endtask

  // Issues one request; leaves results in last_* / lo_*; drops req_valid after completion.
  task automatic xact(int k, bit we, logic [2:0] f3, logic [8:0] a, logic [31:0] wd);
    req_valid_a[k] = 1'b1;
    req_we_a[k]    = we;
    req_f3_a[k]    = f3;
    req_addr_a[k]  = a;
    req_wdata_a[k] = wd;
    last_lat = -1;
    last_stalls = 0;
    last_to = 1'b1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (resp_valid_a[k]) begin
        last_lat = c;
        last_to  = 1'b0;
        last_cyc = cycle_cnt;
        lo_rdata = resp_rdata_a[k];
        lo_fault = fault_a[k];
        lo_wr    = wr_a[k];
        lo_rd    = rd_a[k];
        lo_addr  = addr_a[k];
        lo_wdata = wr_data_a[k];
        lo_rword = rd_data_a[k];
        break;
      end
      if (stall_a[k]) last_stalls++;
    end
    if (!last_to && we && is_legal(we, f3, a)) model_store(k, f3, a, wd);
    @(posedge clk);
    #1;
    req_valid_a[k] = 1'b0;
  endtask

  task automatic test_reset();
    for (int k = 0; k < 3; k++) begin
      req_valid_a[k] = 1'b0; req_we_a[k] = 1'b0; req_f3_a[k] = 3'd0;
      req_addr_a[k] = 9'd0; req_wdata_a[k] = 32'd0;
    end
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      vectors++;
      if ({stall_a[k], resp_valid_a[k], fault_a[k], wr_a[k], rd_a[k]} !== 5'd0 ||
          resp_rdata_a[k] !== 32'd0 || addr_a[k] !== 9'd0 ||
          wr_data_a[k] !== 32'd0 || rd_data_a[k] !== 32'd0) begin
        miscompares++;
        $display("FAIL reset inst%0d: ctl=%b rdata=%h addr=%h wdata=%h rword=%h, required all zero",
                 k, {stall_a[k], resp_valid_a[k], fault_a[k], wr_a[k], rd_a[k]},
                 resp_rdata_a[k], addr_a[k], wr_data_a[k], rd_data_a[k]);
      end
    end
    reset = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_word_access();
    xact(0, 1'b1, 3'd2, 9'h010, 32'hDEADBEEF);
    vectors++;
    if (last_lat !== 2 || last_stalls !== 2 || lo_wr !== 1'b1 || lo_rd !== 1'b0 ||
        lo_wdata !== 32'hDEADBEEF) begin
      miscompares++;
      $display("FAIL sw_basic: lat=%0d stalls=%0d wr=%b rd=%b wr_data=%h, required 2 2 1 0 deadbeef",
               last_lat, last_stalls, lo_wr, lo_rd, lo_wdata);
    end
    xact(0, 1'b0, 3'd2, 9'h010, 32'd0);
    vectors++;
    if (lo_rdata !== 32'hDEADBEEF || lo_rd !== 1'b1 || lo_rword !== 32'hDEADBEEF || last_lat !== 2) begin
      miscompares++;
      $display("FAIL lw_basic: rdata=%h rd=%b rd_data=%h lat=%0d, required deadbeef 1 deadbeef 2",
               lo_rdata, lo_rd, lo_rword, last_lat);
    end
  endtask

  task automatic test_byte_access();
    xact(0, 1'b1, 3'd0, 9'h013, 32'h00000080);
    xact(0, 1'b0, 3'd0, 9'h013, 32'd0);
    vectors++;
    if (lo_rdata !== 32'hFFFFFF80) begin
      miscompares++;
      $display("FAIL lb_sext: got %h required ffffff80", lo_rdata);
    end
    xact(0, 1'b0, 3'd4, 9'h013, 32'd0);
    vectors++;
    if (lo_rdata !== 32'h00000080) begin
      miscompares++;
      $display("FAIL lbu_zext: got %h required 00000080", lo_rdata);
    end
    xact(0, 1'b0, 3'd2, 9'h010, 32'd0);
    vectors++;
    if (lo_rdata !== 32'h80ADBEEF) begin
      miscompares++;
      $display("FAIL sb_merge: got %h required 80adbeef", lo_rdata);
    end
  endtask

  task automatic test_half_access();
    xact(0, 1'b1, 3'd2, 9'h020, 32'd0);
    xact(0, 1'b1, 3'd1, 9'h022, 32'h00008234);
    vectors++;
    if (lo_wdata !== 32'h82340000) begin
      miscompares++;
      $display("FAIL sh_wr_data: got %h required 82340000", lo_wdata);
    end
    xact(0, 1'b0, 3'd1, 9'h022, 32'd0);
    vectors++;
    if (lo_rdata !== 32'hFFFF8234) begin
      miscompares++;
      $display("FAIL lh_sext: got %h required ffff8234", lo_rdata);
    end
    xact(0, 1'b0, 3'd5, 9'h022, 32'd0);
    vectors++;
    if (lo_rdata !== 32'h00008234) begin
      miscompares++;
      $display("FAIL lhu_zext: got %h required 00008234", lo_rdata);
    end
    xact(0, 1'b0, 3'd2, 9'h020, 32'd0);
    vectors++;
    if (lo_rdata !== 32'h82340000) begin
      miscompares++;
      $display("FAIL sh_merge: got %h required 82340000", lo_rdata);
    end
  endtask

  task automatic test_faults();
    logic [2:0] f3s [3] = '{3'd2, 3'd1, 3'd3};
    bit         wes [3] = '{1'b0, 1'b1, 1'b0};
    logic [8:0] as  [3] = '{9'h011, 9'h013, 9'h010};
    for (int i = 0; i < 3; i++) begin
      xact(0, wes[i], f3s[i], as[i], 32'h12345678);
      vectors++;
      if (last_lat !== 1 || lo_fault !== 1'b1 || lo_wr !== 1'b0 || lo_rd !== 1'b0 ||
          lo_rdata !== 32'd0) begin
        miscompares++;
        $display("FAIL fault%0d: lat=%0d fault=%b wr=%b rd=%b rdata=%h, required 1 1 0 0 0",
                 i, last_lat, lo_fault, lo_wr, lo_rd, lo_rdata);
      end
    end
    xact(0, 1'b0, 3'd2, 9'h010, 32'd0);
    vectors++;
    if (lo_rdata !== 32'h80ADBEEF || lo_fault !== 1'b0) begin
      miscompares++;
      $display("FAIL fault_no_write: rdata=%h fault=%b, required 80adbeef 0", lo_rdata, lo_fault);
    end
  endtask

  task automatic fill_all();
    for (int k = 0; k < 3; k++) begin
      int timeouts = 0;
      for (int w = 0; w < 128; w++) begin
        xact(k, 1'b1, 3'd2, 9'(w * 4), $urandom);
        if (last_to) timeouts++;
      end
      vectors++;
      if (timeouts != 0) begin
        miscompares++;
        $display("FAIL fill inst%0d: %0d timeouts, required 0", k, timeouts);
      end
    end
  endtask

  task automatic test_back_to_back();
    int prev_cyc;
    logic [31:0] exp;
    prev_cyc = 0;
    for (int i = 0; i < 4; i++) begin
      logic [8:0] a;
      a = 9'(9'h100 + i * 4);
      exp = model_load(1, 3'd2, a);
      xact(1, 1'b0, 3'd2, a, 32'd0);
      vectors++;
      if (last_lat !== 1 || last_stalls !== 1 || lo_rdata !== exp ||
          (i > 0 && last_cyc - prev_cyc !== 2)) begin
        miscompares++;
        $display("FAIL b2b%0d: lat=%0d stalls=%0d rdata=%h gap=%0d, required 1 1 %h 2",
                 i, last_lat, last_stalls, lo_rdata, last_cyc - prev_cyc, exp);
      end
      prev_cyc = last_cyc;
    end
    exp = model_load(2, 3'd2, 9'h010);
    xact(2, 1'b0, 3'd2, 9'h010, 32'd0);
    vectors++;
    if (last_lat !== 16 || last_stalls !== 16 || lo_rdata !== exp) begin
      miscompares++;
      $display("FAIL wait15: lat=%0d stalls=%0d rdata=%h, required 16 16 %h",
               last_lat, last_stalls, lo_rdata, exp);
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 3; k++) begin
      int n;
      n = (k == 2) ? 40 : 150;
      for (int t = 0; t < n; t++) begin
        bit          we;
        bit          leg;
        logic [2:0]  f3;
        logic [8:0]  a;
        logic [31:0] wd;
        logic [31:0] exp_load;
        int          exp_lat;
        int          idx;
        we = 1'($urandom_range(0, 1));
        f3 = 3'($urandom_range(0, 7));
        if ($urandom_range(0, 3) != 0) begin
          if (we) f3 = 3'($urandom_range(0, 2));
          else begin
            idx = $urandom_range(0, 4);
            f3 = 3'((idx < 3) ? idx : idx + 1);
          end
        end
        a = 9'($urandom_range(0, 511));
        if ($urandom_range(0, 3) != 0) begin
          if (f3[1:0] == 2'd1) a[0] = 1'b0;
          if (f3[1:0] == 2'd2) a[1:0] = 2'b00;
        end
        wd = $urandom;
        leg = is_legal(we, f3, a);
        exp_lat = leg ? wait_of(k) + 1 : 1;
        exp_load = leg && !we ? model_load(k, f3, a) : 32'd0;
        xact(k, we, f3, a, wd);
        vectors++;
        if (last_to || last_lat !== exp_lat || last_stalls !== exp_lat || lo_fault !== !leg ||
            lo_wr !== (leg && we) || lo_rd !== (leg && !we) || lo_addr !== a) begin
          miscompares++;
          $display("FAIL rnd_ctl inst%0d we=%b f3=%0d a=%h: lat=%0d stalls=%0d fault=%b wr=%b rd=%b addr=%h, required lat=%0d fault=%b wr=%b rd=%b addr=%h",
                   k, we, f3, a, last_lat, last_stalls, lo_fault, lo_wr, lo_rd, lo_addr,
                   exp_lat, !leg, leg && we, leg && !we, a);
        end
        vectors++;
        if (!leg && lo_rdata !== 32'd0) begin
          miscompares++;
          $display("FAIL rnd_fault_rdata inst%0d: got %h required 0", k, lo_rdata);
        end else if (leg && !we && (lo_rdata !== exp_load || lo_rword !== model_word(k, a))) begin
          miscompares++;
          $display("FAIL rnd_load inst%0d f3=%0d a=%h: rdata=%h rd_data=%h, required %h %h",
                   k, f3, a, lo_rdata, lo_rword, exp_load, model_word(k, a));
        end else if (leg && we && lo_wdata !== model_word(k, a)) begin
          miscompares++;
          $display("FAIL rnd_store inst%0d f3=%0d a=%h: wr_data=%h, required %h",
                   k, f3, a, lo_wdata, model_word(k, a));
        end
      end
    end
  endtask

  task automatic test_reset_in_busy();
    xact(0, 1'b1, 3'd2, 9'h040, 32'h22222222);
    req_valid_a[0] = 1'b1;
    req_we_a[0]    = 1'b1;
    req_f3_a[0]    = 3'd2;
    req_addr_a[0]  = 9'h040;
    req_wdata_a[0] = 32'h11111111;
    @(posedge clk);
    #1;
    reset = 1'b1;
    req_valid_a[0] = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    vectors++;
    if (resp_valid_a[0] !== 1'b0 || wr_a[0] !== 1'b0 || stall_a[0] !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_busy_state: resp_valid=%b wr=%b stall=%b, required 0 0 0",
               resp_valid_a[0], wr_a[0], stall_a[0]);
    end
    @(posedge clk);
    #1;
    vectors++;
    if (resp_valid_a[0] !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_busy_no_resp: resp_valid=%b required 0", resp_valid_a[0]);
    end
    xact(0, 1'b0, 3'd2, 9'h040, 32'd0);
    vectors++;
    if (lo_rdata !== 32'h22222222) begin
      miscompares++;
      $display("FAIL reset_busy_discard: got %h required 22222222", lo_rdata);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_word_access();
    test_byte_access();
    test_half_access();
    test_faults();
    fill_all();
    test_back_to_back();
    test_random();
    test_reset_in_busy();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
